// File: rtl/mannix_mem_pkg.sv
// Shared memory-side constants, line type and write-packer FSM state encoding.
package mannix_mem_pkg;

   localparam int MEM_WORD_WIDTH    = 8;
   localparam int MEM_WORDS_IN_LINE = 32;
   localparam int MEM_ADDR_WIDTH    = 19;

   typedef logic [MEM_WORDS_IN_LINE-1:0][MEM_WORD_WIDTH-1:0] mem_line_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_REQ  = 2'd2
   } wr_state_e;

endpackage

// File: rtl/wr_line_buf.sv
// One line register filled slot by slot; sealed (full) when the last slot or the
// job's final word is written, and zero-cleared when its line has been granted.
module wr_line_buf
   import mannix_mem_pkg::*;
#(
   parameter int WORD_WIDTH        = MEM_WORD_WIDTH,
   parameter int NUM_WORDS_IN_LINE = MEM_WORDS_IN_LINE
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         clr_i,
   input  logic                                         wr_en_i,
   input  logic                                         wr_last_i,
   input  logic [WORD_WIDTH-1:0]                        wr_data_i,
   output logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0] data_o,
   output logic [$clog2(NUM_WORDS_IN_LINE+1)-1:0]       count_o,
   output logic                                         full_o,
   output logic                                         last_o
);

   localparam int CW = $clog2(NUM_WORDS_IN_LINE + 1);

   logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]                                idx_q, idx_d;
   logic                                         full_q, full_d;
   logic                                         last_q, last_d;
   logic [NUM_WORDS_IN_LINE-1:0]                 slot_we;

   generate
      for (genvar gi = 0; gi < NUM_WORDS_IN_LINE; gi++) begin : g_slot
         assign slot_we[gi] = wr_en_i && (idx_q == CW'(gi));
      end
   endgenerate

   always_comb begin
      data_d = data_q;
      idx_d  = idx_q;
      full_d = full_q;
      last_d = last_q;
      if (clr_i) begin
         data_d = '0;
         idx_d  = '0;
         full_d = 1'b0;
         last_d = 1'b0;
      end else if (wr_en_i) begin
         for (int k = 0; k < NUM_WORDS_IN_LINE; k++) begin
            if (slot_we[k]) data_d[k] = wr_data_i;
         end
         idx_d  = idx_q + CW'(1);
         full_d = (idx_q == CW'(NUM_WORDS_IN_LINE - 1)) || wr_last_i;
         last_d = wr_last_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         idx_q  <= '0;
         full_q <= 1'b0;
         last_q <= 1'b0;
      end else begin
         data_q <= data_d;
         idx_q  <= idx_d;
         full_q <= full_d;
         last_q <= last_d;
      end
   end

   assign data_o  = data_q;
   assign count_o = idx_q;
   assign full_o  = full_q;
   assign last_o  = last_q;

endmodule

// File: rtl/wr_line_packer.sv
// Packs a word stream into memory lines and issues one write request per line.
// Define WR_PACKER_DOUBLE_BUF_EN for two ping-pong line buffers (default: one).
module wr_line_packer
   import mannix_mem_pkg::*;
#(
   parameter int WORD_WIDTH        = MEM_WORD_WIDTH,
   parameter int NUM_WORDS_IN_LINE = MEM_WORDS_IN_LINE,
   parameter int ADDR_WIDTH        = MEM_ADDR_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    cfg_start,
   input  logic [ADDR_WIDTH-1:0]                   cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0]                   cfg_num_words,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [WORD_WIDTH-1:0]                   in_data,
   output logic                                    mem_req,
   input  logic                                    mem_gnt,
   output logic [ADDR_WIDTH-1:0]                   mem_start_addr,
   output logic [ADDR_WIDTH-1:0]                   mem_size_bytes,
   output logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] mem_data,
   output logic [$clog2(NUM_WORDS_IN_LINE)-1:0]    mem_last_valid,
   output logic                                    last,
   output logic                                    busy,
   output logic                                    done
);

`ifdef WR_PACKER_DOUBLE_BUF_EN
   localparam int NBUF = 2;
`else
   localparam int NBUF = 1;
`endif
   localparam int CW  = $clog2(NUM_WORDS_IN_LINE + 1);
   localparam int LVW = $clog2(NUM_WORDS_IN_LINE);

   typedef logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0] line_t;

   wr_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] rem_q, rem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  fill_sel_q, fill_sel_d;
   logic                  req_sel_q, req_sel_d;
   logic                  done_q, done_d;

   logic [NBUF-1:0]       buf_wr, buf_clr, buf_full, buf_last;
   logic [CW-1:0]         buf_count [NBUF];
   line_t                 buf_data  [NBUF];
   logic                  accept, grant, final_word, seal_now;
   logic [CW-1:0]         req_cnt;

   generate
      for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
         assign buf_wr[gi]  = accept && (fill_sel_q == 1'(gi));
         assign buf_clr[gi] = grant && (req_sel_q == 1'(gi));
         wr_line_buf #(
            .WORD_WIDTH        (WORD_WIDTH),
            .NUM_WORDS_IN_LINE (NUM_WORDS_IN_LINE)
         ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .clr_i     (buf_clr[gi]),
            .wr_en_i   (buf_wr[gi]),
            .wr_last_i (final_word),
            .wr_data_i (in_data),
            .data_o    (buf_data[gi]),
            .count_o   (buf_count[gi]),
            .full_o    (buf_full[gi]),
            .last_o    (buf_last[gi])
         );
      end
   endgenerate

   // Filling stops when the target buffer is still awaiting its grant or the job is drained.
   assign in_ready   = (state_q != ST_IDLE) && (rem_q != '0) && !buf_full[fill_sel_q];
   assign accept     = in_valid && in_ready;
   assign mem_req    = (state_q == ST_REQ);
   assign grant      = mem_req && mem_gnt;
   assign final_word = (rem_q == ADDR_WIDTH'(1));
   assign seal_now   = accept && ((buf_count[fill_sel_q] == CW'(NUM_WORDS_IN_LINE - 1)) || final_word);

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      addr_d     = addr_q;
      fill_sel_d = fill_sel_q;
      req_sel_d  = req_sel_q;
      done_d     = 1'b0;

      if (accept) rem_d = rem_q - ADDR_WIDTH'(1);
      if (seal_now && NBUF == 2) fill_sel_d = ~fill_sel_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               if (cfg_num_words == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = ST_FILL;
                  rem_d      = cfg_num_words;
                  addr_d     = cfg_base_addr;
                  fill_sel_d = 1'b0;
                  req_sel_d  = 1'b0;
               end
            end
         end
         ST_FILL: begin
            // Requests follow fill order: only the buffer at req_sel may launch.
            if (buf_full[req_sel_q] || (seal_now && fill_sel_q == req_sel_q)) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (mem_gnt) begin
               addr_d = addr_q + ADDR_WIDTH'(NUM_WORDS_IN_LINE);
               if (buf_last[req_sel_q]) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_FILL;
                  if (NBUF == 2) req_sel_d = ~req_sel_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         addr_q     <= '0;
         fill_sel_q <= 1'b0;
         req_sel_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         addr_q     <= addr_d;
         fill_sel_q <= fill_sel_d;
         req_sel_q  <= req_sel_d;
         done_q     <= done_d;
      end
   end

   // A sealed buffer is never written, so its registers hold the request steady.
   assign req_cnt        = buf_count[req_sel_q];
   assign mem_start_addr = mem_req ? addr_q : '0;
   assign mem_size_bytes = mem_req ? ADDR_WIDTH'(req_cnt) : '0;
   assign mem_last_valid = mem_req ? (req_cnt[LVW-1:0] - LVW'(1)) : '0;
   assign last           = mem_req && buf_last[req_sel_q];
   assign mem_data       = mem_req ? buf_data[req_sel_q] : '0;
   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;

endmodule

// File: doc/wr_line_packer.md
# wr_line_packer

Write-back line packer that sits directly upstream of the memory write port. Accepts a byte stream from a compute engine, such as activation or pooling output, and packs it into lines of `NUM_WORDS_IN_LINE` words. For each line it issues one write request, with start address, byte count, last-valid index and job-last flag, using the `mem_req`/`mem_gnt` handshake of the client write side.

## Interface
Parameters:
- `WORD_WIDTH`, default 8: bits per word (byte).
- `NUM_WORDS_IN_LINE`, default 32: words per memory line.
- `ADDR_WIDTH`, default 19: byte address and size width.

Ports:
- `clk`, input, 1: single clock for the block.
- `rst`, input, 1: synchronous, active-high reset.
- `cfg_start`, input, 1: one-cycle job start pulse. Ignored while `busy`.
- `cfg_base_addr`, input, ADDR_WIDTH: job byte base address, sampled on `cfg_start`.
- `cfg_num_words`, input, ADDR_WIDTH: total words in the job, sampled on `cfg_start`.
- `in_valid`, input, 1: input word valid.
- `in_ready`, output, 1: block accepts a word this cycle.
- `in_data`, input, WORD_WIDTH: input word.
- `mem_req`, output, 1: write request.
- `mem_gnt`, input, 1: write grant.
- `mem_start_addr`, output, ADDR_WIDTH: line byte address.
- `mem_size_bytes`, output, ADDR_WIDTH: valid bytes in this line, range 1..NUM_WORDS_IN_LINE.
- `mem_data`, output, NUM_WORDS_IN_LINE×WORD_WIDTH: packed line. Word k sits at index k.
- `mem_last_valid`, output, $clog2(NUM_WORDS_IN_LINE): index of the last valid word, equal to `mem_size_bytes`−1.
- `last`, output, 1: this request is the final line of the job.
- `busy`, output, 1: job in progress.
- `done`, output, 1: one-cycle pulse when the job completes.

## Operation
- **FSM states:** IDLE, FILL, REQ.
- **IDLE → FILL:** on `cfg_start` with `cfg_num_words`≠0. Latch base address and remaining count; set the fill index and line offset to 0.
- **IDLE with zero count:** `cfg_start` with `cfg_num_words`=0 gives a `done` pulse the next cycle. No request is issued and `busy` stays 0.
- **FILL:** `in_ready`=1. Each `in_valid`&&`in_ready` writes `in_data` into line slot `fill_idx`, increments `fill_idx` and decrements the remaining count.
  - FILL → REQ when the line fills (`fill_idx` reaches N) or the remaining count reaches 0.
- **REQ:**
  - `mem_req`=1.
  - `mem_start_addr` = base + line_offset, computed mod 2^ADDR_WIDTH.
  - `mem_size_bytes` = words in the line; `last` = (remaining==0).
  - Slots beyond `mem_last_valid` are driven 0.
  - On `mem_gnt`: line_offset += N. If `last`, go to IDLE and pulse `done`; otherwise go to FILL with `fill_idx`=0.
- **`busy`:** 1 from the cycle after `cfg_start` until the cycle `done` is high. `done` and `busy` are never both 1.
- **Request field stability:** all request fields are registered and stay stable while `mem_req`=1 and `mem_gnt`=0.
- **Reset:** effective on any cycle, including mid-REQ. The block returns to IDLE with all outputs 0 (`in_ready`=0, `mem_req`=0, `mem_data`=0, `busy`=0, `done`=0). The pending line is discarded.

## Timing
- A transfer completes in the cycle where `mem_req`&&`mem_gnt` are both 1. `mem_gnt` without `mem_req` is ignored.
- `mem_req` rises the cycle after the final word of a line is accepted.
- After a grant, the earliest next `mem_req` is 1 cycle later, and only if that line is already filled (double-buffer build).
- `in_ready` is combinational from state only, never from `in_valid`.
- `done` is asserted the cycle after the grant of the `last` line.
- Throughput, single buffer: N accept cycles + 1 request cycle minimum per line.

## Configuration
- Macro: `WR_PACKER_DOUBLE_BUF_EN`.
- **Undefined:** one line buffer. `in_ready`=0 throughout REQ.
- **Defined:** two line buffers, used ping-pong.
  - Filling continues into the idle buffer while the other buffer is requesting.
  - `in_ready`=0 only when both buffers are full, or when the job's words are exhausted.
  - Requests are issued strictly in fill order.
  - `done` follows the grant of the `last` line.

## Structure
- **Shared package `mannix_mem_pkg`:** holds the default WORD_WIDTH, NUM_WORDS_IN_LINE and ADDR_WIDTH constants, the line typedef (`logic [N-1:0][W-1:0]`) and the FSM state enum.
- **Sub-module `wr_line_buf`:** one line register with per-slot write enable, a fill index, zero-clear, and a full/count output. It is instantiated once, or twice when `WR_PACKER_DOUBLE_BUF_EN` is defined.

## Test plan
Default parameters (N=32, ADDR_WIDTH=19) unless stated.
- **Two full lines:** base 0x00100, num 64, continuous `in_valid`, `mem_gnt` tied 1 → two requests.
  - Request 1: addr 0x00100, size 32, last_valid 31, last 0.
  - Request 2: addr 0x00120, size 32, last_valid 31, last 1.
  - `done` one cycle after the second grant.
- **Partial tail:** num 40 → second request has size 8, last_valid 7, last 1. Data slots 8..31 are 0.
- **Grant backpressure:** `mem_gnt` held 0 for 10 cycles during REQ → all request fields stable.
  - Single buffer: `in_ready`=0.
  - `WR_PACKER_DOUBLE_BUF_EN` build: 32 further words accepted, then `in_ready`=0.
- **Zero-length job and ignored restart:** num 0 → `done` the next cycle, no `mem_req`, `busy` stays 0. `cfg_start` while `busy` → ignored.
- **Address wrap:** base 0x7FFF0, num 64 → second request addr 0x00010.
- **Reset mid-operation:** `rst` in a REQ cycle → next cycle `mem_req`=0, `busy`=0, `in_ready`=0. A new job then runs normally.
